// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle ARMv4-subset core.
// Optional perf counters under `MCFSM_PERF_EN (cycle_cnt, instr_cnt).
module mc_main_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       irwrite,
    output logic       nextpc,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       aluop,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic       nowrite,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
`ifdef MCFSM_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t st;
    state_t nxt;
    logic   flagonly;

    assign state    = st;
    // CMP and TST only update flags, so they skip ALUWB
    assign flagonly = (funct[4:1] == 4'b1010) || (funct[4:1] == 4'b1000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= S_FETCH;
        end else begin
            st <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else if (st == S_DECODE && op == 2'b11) begin
            illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt        = st;
        irwrite    = 1'b0;
        nextpc     = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        aluop      = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        nowrite    = 1'b0;
        instr_done = 1'b0;
        case (st)
            S_FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                nextpc    = mem_ready;
                if (mem_ready) nxt = S_DECODE;
            end
            S_DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                unique case (1'b1)
                    (op == 2'b01): nxt = S_MEMADR;
                    (op == 2'b00): nxt = funct[5] ? S_EXECI : S_EXECR;
                    (op == 2'b10): nxt = S_BRANCH;
                    (op == 2'b11): begin
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrcb = 2'b01;
                nxt     = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regw       = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                alusrcb    = (st == S_EXECI) ? 2'b01 : 2'b00;
                aluop      = 1'b1;
                nowrite    = flagonly;
                instr_done = flagonly;
                nxt        = flagonly ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                regw       = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                alusrcb    = 2'b01;
                resultsrc  = 2'b10;
                branch     = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

`ifdef MCFSM_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (instr_done) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
